// File: rtl/bit_diff_pkg.sv
// Shared types and helpers for the multi-bit bit-difference coprocessor.
package bit_diff_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE,
        XXX = 'x
    } state_t;

    typedef enum logic {
        MODE_DIFF     = 1'b0,
        MODE_POPCOUNT = 1'b1
    } mode_t;

    // Signed width able to hold every value in [-w, +w].
    function automatic int result_width(int w);
        return $clog2(2 * w + 1);
    endfunction

endpackage

// File: rtl/bit_diff_slice.sv
// Combinational per-cycle contribution of K bits: ones minus zeros, or ones only.
module bit_diff_slice
    import bit_diff_pkg::*;
#(
    parameter int unsigned K  = 4,
    parameter int unsigned RW = 6
) (
    input  logic [K-1:0]          bits,
    input  mode_t                 mode,
    output logic signed [RW-1:0]  contrib
);

    localparam logic signed [RW-1:0] KS = RW'(K);

    logic signed [RW-1:0] ones;

    // Count the ones, then map to the requested contribution; wraps are harmless
    // because the true result always fits in RW signed bits.
    always_comb begin
        ones = '0;
        for (int unsigned i = 0; i < K; i++) begin
            ones = ones + RW'(bits[i]);
        end
        contrib = (mode == MODE_POPCOUNT) ? ones : (ones <<< 1) - KS;
    end

endmodule

// File: rtl/bit_diff_multi.sv
// Go/done bit-difference coprocessor consuming BITS_PER_CYCLE bits per cycle.
// Optional: define BIT_DIFF_EARLY_EXIT_EN to finish as soon as the remaining
// shifted operand is zero (result unchanged, latency 1..ITERS).
module bit_diff_multi
    import bit_diff_pkg::*;
#(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned BITS_PER_CYCLE = 4,
    localparam int unsigned RW            = result_width(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     data,
    output logic signed [RW-1:0] result,
    output logic                 done,
    output logic                 busy
);

    localparam int unsigned ITERS = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    if (WIDTH < 1 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
        $error("bit_diff_multi: BITS_PER_CYCLE must be >= 1 and divide WIDTH >= 1");
    end

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     data_q, data_d;
    mode_t                mode_q, mode_d;
    logic signed [RW-1:0] acc_q, acc_d;
    logic [CW-1:0]        count_q, count_d;
    logic signed [RW-1:0] result_q, result_d;
    logic signed [RW-1:0] contrib;
    logic signed [RW-1:0] acc_next;

`ifdef BIT_DIFF_EARLY_EXIT_EN
    // Zeros still unconsumed each count -1 in diff mode.
    logic signed [RW-1:0] remaining;
    assign remaining = RW'((ITERS - 32'(count_q)) * BITS_PER_CYCLE);
`endif

    bit_diff_slice #(
        .K  (BITS_PER_CYCLE),
        .RW (RW)
    ) u_slice (
        .bits    (data_q[BITS_PER_CYCLE-1:0]),
        .mode    (mode_q),
        .contrib (contrib)
    );

    assign acc_next = acc_q + contrib;

    // Next-state and datapath updates; go is only honoured outside COMPUTE.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        mode_d   = mode_q;
        acc_d    = acc_q;
        count_d  = count_q;
        result_d = result_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (go) begin
                    data_d  = data;
                    mode_d  = mode_t'(mode);
                    acc_d   = '0;
                    count_d = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
`ifdef BIT_DIFF_EARLY_EXIT_EN
                if (data_q == '0) begin
                    result_d = (mode_q == MODE_POPCOUNT) ? acc_q : acc_q - remaining;
                    state_d  = DONE;
                end else
`endif
                begin
                    acc_d   = acc_next;
                    data_d  = data_q >> BITS_PER_CYCLE;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST) begin
                        result_d = acc_next;
                        state_d  = DONE;
                    end
                end
            end
            default: state_d = XXX;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            data_q   <= '0;
            mode_q   <= MODE_DIFF;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            mode_q   <= mode_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

    // done/busy are pure state decodes so they can never disagree with the FSM.
    always_comb begin
        result = result_q;
        done   = (state_q == DONE);
        busy   = (state_q == COMPUTE);
    end

endmodule

// File: tb/tb_bit_diff_multi.sv
// Self-checking bench: three instances (4, 1 and 16 bits per cycle) against a
// behavioural model built from popcount arithmetic.
module tb_bit_diff_multi;

    localparam int W  = 16;
    localparam int RW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 go_v   [3];
    logic                 mode_v [3];
    logic [W-1:0]         data_v [3];
    logic signed [RW-1:0] res_v  [3];
    logic                 done_v [3];
    logic                 busy_v [3];

    int checks = 0;
    int errors = 0;

    bit_diff_multi #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .go(go_v[0]), .mode(mode_v[0]), .data(data_v[0]),
        .result(res_v[0]), .done(done_v[0]), .busy(busy_v[0])
    );
    bit_diff_multi #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .go(go_v[1]), .mode(mode_v[1]), .data(data_v[1]),
        .result(res_v[1]), .done(done_v[1]), .busy(busy_v[1])
    );
    bit_diff_multi #(.WIDTH(W), .BITS_PER_CYCLE(16)) u_dut16 (
        .clk(clk), .rst(rst), .go(go_v[2]), .mode(mode_v[2]), .data(data_v[2]),
        .result(res_v[2]), .done(done_v[2]), .busy(busy_v[2])
    );

    function automatic int bpc(int k);
        return (k == 0) ? 4 : (k == 1) ? 1 : 16;
    endfunction

    // Popcount for mode 1, ones minus zeros otherwise.
    function automatic int ref_result(logic [W-1:0] d, logic m);
        int ones;
        ones = $countones(d);
        return m ? ones : ones - (W - ones);
    endfunction

    // Cycles from the accepting edge until done is observed.
    function automatic int ref_lat(logic [W-1:0] d, int b);
        int iters;
        iters = W / b;
`ifdef BIT_DIFF_EARLY_EXIT_EN
        for (int c = 0; c < iters; c++) begin
            if ((d >> (c * b)) == '0) return c + 1;
        end
`endif
        return iters;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One full operation on instance k, checking done drop, latency, busy span, result.
    task automatic run_op(input int k, input logic [W-1:0] d, input logic m, input string tag);
        int n;
        int busy_n;
        int exp_lat;
        exp_lat = ref_lat(d, bpc(k));
        @(negedge clk);
        go_v[k]   = 1'b1;
        data_v[k] = d;
        mode_v[k] = m;
        @(posedge clk);
        #1;
        go_v[k]   = 1'b0;
        data_v[k] = W'($urandom);
        check({tag, " done_low_after_go"}, int'(done_v[k]), 0);
        n = 0;
        busy_n = 0;
        while (!done_v[k] && n < 64) begin
            if (busy_v[k]) busy_n++;
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " latency"}, n, exp_lat);
        check({tag, " busy_cycles"}, busy_n, exp_lat);
        check({tag, " busy_low_at_done"}, int'(busy_v[k]), 0);
        check({tag, " result"}, int'(res_v[k]), ref_result(d, m));
    endtask

    initial begin
        int n;
        int held;
        logic [W-1:0] d;
        logic m;
        for (int k = 0; k < 3; k++) begin
            go_v[k] = 1'b0;
            mode_v[k] = 1'b0;
            data_v[k] = '0;
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("reset done", int'(done_v[k]), 0);
            check("reset busy", int'(busy_v[k]), 0);
            check("reset result", int'(res_v[k]), 0);
        end
        @(negedge clk);
        rst = 1'b1;

        run_op(0, 16'hFFFF, 1'b0, "ffff_diff");
        run_op(0, 16'h0000, 1'b0, "0000_diff");
        run_op(0, 16'h00F0, 1'b1, "00f0_pop_from_done");

        // Result must hold while idle in DONE.
        repeat (3) @(posedge clk);
        #1;
        check("result_held", int'(res_v[0]), 4);
        check("done_held", int'(done_v[0]), 1);

        // Reset during the second COMPUTE cycle discards the operation.
        @(negedge clk);
        go_v[0] = 1'b1;
        data_v[0] = 16'hFFFF;
        mode_v[0] = 1'b1;
        @(posedge clk);
        #1;
        go_v[0] = 1'b0;
        @(posedge clk);
        #1;
        check("pre_reset busy", int'(busy_v[0]), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("midreset done", int'(done_v[0]), 0);
        check("midreset busy", int'(busy_v[0]), 0);
        check("midreset result", int'(res_v[0]), 0);
        run_op(0, 16'h0003, 1'b0, "0003_after_reset");

        // go held high with changing data during COMPUTE must be ignored.
        @(negedge clk);
        go_v[0] = 1'b1;
        data_v[0] = 16'hA5A5;
        mode_v[0] = 1'b0;
        @(posedge clk);
        #1;
        n = 0;
        held = 0;
        while (!done_v[0] && n < 64) begin
            data_v[0] = W'($urandom);
            mode_v[0] = 1'($urandom);
            if (busy_v[0]) held++;
            @(posedge clk);
            #1;
            n++;
        end
        go_v[0] = 1'b0;
        check("held_go latency", n, ref_lat(16'hA5A5, 4));
        check("held_go busy_cycles", held, ref_lat(16'hA5A5, 4));
        check("held_go result", int'(res_v[0]), 0);

        run_op(0, 16'h0001, 1'b0, "0001_diff");

        // Randomised sweeps across all three bit-per-cycle configurations.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 12; i++) begin
                d = W'($urandom);
                if (i == 0) d = '0;
                if (i == 1) d = 16'h8000;
                m = 1'($urandom);
                run_op(k, d, m, $sformatf("sweep_k%0d_i%0d", bpc(k), i));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
